// File: rtl/nios2_debug_pkg.sv
// nios2_debug_pkg: state encoding and jdo field positions shared by the OCI memory engine
package nios2_debug_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_RD_REQ, ST_RD_WAIT, ST_WR_REQ} state_e;
    localparam int JDO_ADDR_HI  = 33;
    localparam int JDO_ADDR_LO  = 26;
    localparam int JDO_RD       = 35;
    localparam int JDO_WDATA_HI = 34;
    localparam int JDO_WDATA_LO = 3;
endpackage

// File: rtl/nios2_debug_timeout_ctr.sv
// nios2_debug_timeout_ctr: counts busy cycles and flags when an access has run LIMIT cycles
module nios2_debug_timeout_ctr #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int W = $clog2(LIMIT + 1);
    logic [W-1:0] cnt_q;
    // restart on every state entry, otherwise count while the engine is busy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else if (clr_i) cnt_q <= '0;
        else if (en_i) cnt_q <= cnt_q + 1'b1;
    end
    assign expired_o = en_i && !clr_i && (cnt_q == W'(LIMIT - 1));
endmodule

// File: rtl/nios2_debug_ocimem_engine.sv
// nios2_debug_ocimem_engine: turns debug-slave jdo commands into single-word debug RAM accesses; access timeout enabled by NIOS2_DEBUG_OCIMEM_TIMEOUT_EN
module nios2_debug_ocimem_engine
    import nios2_debug_pkg::*;
#(
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    input  logic              mem_waitrequest,
    input  logic [31:0]       mem_readdata,
    input  logic              mem_readdatavalid,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic              busy
);
    state_e            state_q;
    logic [ADDR_W-1:0] mon_a_q;
    logic [31:0]       mon_d_q;
    logic [31:0]       wdata_q;
    logic              rd_q, wr_q, ready_q, err_q, busy_q;
    logic [ADDR_W-1:0] addr_inc_w;
    logic              any_stb_w, done_w, timeout_w, unused_w;

    assign addr_inc_w = mon_a_q + 1'b1;
    assign any_stb_w  = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    assign done_w     = (state_q == ST_RD_WAIT && mem_readdatavalid) || (state_q == ST_WR_REQ && !mem_waitrequest);
    assign unused_w   = ^{jdo[37:36], jdo[2:0], TIMEOUT_CYCLES != 0};

`ifdef NIOS2_DEBUG_OCIMEM_TIMEOUT_EN
    logic tmo_clr_w;
    assign tmo_clr_w = !busy_q || (state_q == ST_RD_REQ && !mem_waitrequest);
    nios2_debug_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (tmo_clr_w),
        .en_i     (busy_q),
        .expired_o(timeout_w)
    );
`else
    assign timeout_w = 1'b0;
`endif

    // command decode in IDLE, bus handshake otherwise; every output is a register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mon_a_q <= '0;
            mon_d_q <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (take_action_ocimem_b) begin
                        wdata_q <= jdo[JDO_WDATA_HI:JDO_WDATA_LO];
                        wr_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                        err_q   <= 1'b0;
                        state_q <= ST_WR_REQ;
                    end else if (take_action_ocimem_a) begin
                        mon_a_q <= ADDR_W'(jdo[JDO_ADDR_HI:JDO_ADDR_LO]);
                        rd_q    <= jdo[JDO_RD];
                        busy_q  <= jdo[JDO_RD];
                        ready_q <= !jdo[JDO_RD];
                        err_q   <= 1'b0;
                        state_q <= jdo[JDO_RD] ? ST_RD_REQ : ST_IDLE;
                    end else if (take_no_action_ocimem_a) begin
                        mon_a_q <= addr_inc_w;
                        rd_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                        err_q   <= 1'b0;
                        state_q <= ST_RD_REQ;
                    end
                end
                ST_RD_REQ: begin
                    if (!mem_waitrequest) begin
                        rd_q    <= 1'b0;
                        state_q <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (mem_readdatavalid) begin
                        mon_d_q <= mem_readdata;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_WR_REQ: begin
                    if (!mem_waitrequest) begin
                        mon_a_q <= addr_inc_w;
                        wr_q    <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            if (state_q != ST_IDLE && any_stb_w) err_q <= 1'b1;
            if (timeout_w && !done_w) begin
                rd_q    <= 1'b0;
                wr_q    <= 1'b0;
                busy_q  <= 1'b0;
                ready_q <= 1'b1;
                err_q   <= 1'b1;
                state_q <= ST_IDLE;
            end
        end
    end

    assign mem_address   = mon_a_q;
    assign mem_read      = rd_q;
    assign mem_write     = wr_q;
    assign mem_writedata = wdata_q;
    assign MonDReg       = mon_d_q;
    assign monitor_ready = ready_q;
    assign monitor_error = err_q;
    assign busy          = busy_q;
endmodule
